// File: rtl/pusch_chain_ctrl_if.sv
// rtl/pusch_chain_ctrl_if.sv - stage start/active/done bundle between the PUSCH sequencer and its stages
interface pusch_chain_ctrl_if;
    logic [5:0] stage_start;
    logic [5:0] stage_active;
    logic [5:0] stage_done;

    modport master (output stage_start, output stage_active, input stage_done);
    modport slave  (input stage_start, input stage_active, output stage_done);
endinterface

// File: rtl/pusch_chain_ctrl.sv
// rtl/pusch_chain_ctrl.sv - PUSCH uplink chain stage sequencer; optional stage watchdog under PUSCH_CTRL_WATCHDOG_EN
module pusch_chain_ctrl #(
    parameter int WDT_W     = 12,
    parameter int WDT_LIMIT = 3000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic                abort,
    input  logic [1:0]          base_graph_in,
    input  logic [1:0]          rv_number_in,
    input  logic [3:0]          process_number_in,
    input  logic [16:0]         available_coded_bits_in,
    input  logic [2:0]          modulation_order_in,
    pusch_chain_ctrl_if.master  stages,
    output logic [1:0]          base_graph,
    output logic [1:0]          rv_number,
    output logic [3:0]          process_number,
    output logic [16:0]         available_coded_bits,
    output logic [2:0]          modulation_order,
    output logic                busy,
    output logic                frame_done,
    output logic [7:0]          frame_cnt,
    output logic                error,
    output logic [2:0]          err_stage
);

    typedef enum logic [3:0] {IDLE, S0, S1, S2, S3, S4, S5, DONE, ERR} state_t;

    state_t     state;
    state_t     state_nxt;
    logic [2:0] cur_idx;
    logic [2:0] nxt_idx;
    logic       cur_is_stage;
    logic       nxt_is_stage;
    logic       accept;
    logic       entry;

    // The last watchdog value WDT_LIMIT-1 must be representable in WDT_W bits.
    if (WDT_LIMIT < 1 || WDT_LIMIT > (1 << WDT_W)) begin : g_wdt_limit_range
        $error("WDT_LIMIT does not fit in WDT_W bits");
    end

`ifdef PUSCH_CTRL_WATCHDOG_EN
    localparam logic [WDT_W-1:0] WDT_LAST = WDT_W'(WDT_LIMIT - 1);
    logic [WDT_W-1:0] wdt_cnt;
`endif

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state; stage_start doubles as the "entry cycle" marker so a done on entry is ignored.
    always_comb begin
        state_nxt    = state;
        accept       = 1'b0;
        cur_is_stage = (state >= S0) && (state <= S5);
        cur_idx      = 3'(state - S0);
        case (state)
            IDLE: begin
                if (enable && !abort) begin
                    accept    = 1'b1;
                    state_nxt = S0;
                end
            end
            S0, S1, S2, S3, S4, S5: begin
                if (stages.stage_done[cur_idx] && !stages.stage_start[cur_idx]) begin
                    state_nxt = (state == S5) ? DONE : state_t'(state + 4'd1);
                end
`ifdef PUSCH_CTRL_WATCHDOG_EN
                else if (wdt_cnt == WDT_LAST) begin
                    state_nxt = ERR;
                end
`endif
            end
            default: state_nxt = IDLE;
        endcase
        if (abort && state != IDLE) begin
            state_nxt = IDLE;
        end
        nxt_is_stage = (state_nxt >= S0) && (state_nxt <= S5);
        nxt_idx      = 3'(state_nxt - S0);
        entry        = nxt_is_stage && (state_nxt != state);
    end

    // Registered outputs derived from the next state, plus configuration capture on accept.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stages.stage_start   <= '0;
            stages.stage_active  <= '0;
            busy                 <= 1'b0;
            frame_done           <= 1'b0;
            frame_cnt            <= '0;
            base_graph           <= '0;
            rv_number            <= '0;
            process_number       <= '0;
            available_coded_bits <= '0;
            modulation_order     <= '0;
        end else begin
            stages.stage_start  <= entry ? (6'b000001 << nxt_idx) : 6'b000000;
            stages.stage_active <= nxt_is_stage ? (6'b000001 << nxt_idx) : 6'b000000;
            busy                <= (state_nxt != IDLE);
            frame_done          <= (state_nxt == DONE);
            if (state_nxt == DONE) begin
                frame_cnt <= frame_cnt + 8'd1;
            end
            if (accept) begin
                base_graph           <= base_graph_in;
                rv_number            <= rv_number_in;
                process_number       <= process_number_in;
                available_coded_bits <= available_coded_bits_in;
                modulation_order     <= modulation_order_in;
            end
        end
    end

`ifdef PUSCH_CTRL_WATCHDOG_EN
    // Cycles spent in the current stage; restarts on every stage entry.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wdt_cnt <= '0;
        end else if (entry || !cur_is_stage) begin
            wdt_cnt <= '0;
        end else begin
            wdt_cnt <= wdt_cnt + WDT_W'(1);
        end
    end

    // Sticky timeout flag and stage index, cleared only by the next accepted frame.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            error     <= 1'b0;
            err_stage <= '0;
        end else if (accept) begin
            error     <= 1'b0;
            err_stage <= '0;
        end else if (state_nxt == ERR) begin
            error     <= 1'b1;
            err_stage <= cur_idx;
        end
    end
`else
    assign error     = 1'b0;
    assign err_stage = 3'd0;
`endif

endmodule

// File: tb/tb_pusch_chain_ctrl.sv
// tb/tb_pusch_chain_ctrl.sv - randomized schedule-model bench for pusch_chain_ctrl
module tb_pusch_chain_ctrl;

    localparam int WDT_LIMIT = 20;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        enable = 1'b0;
    logic        abort = 1'b0;
    logic [1:0]  base_graph_in = '0;
    logic [1:0]  rv_number_in = '0;
    logic [3:0]  process_number_in = '0;
    logic [16:0] available_coded_bits_in = '0;
    logic [2:0]  modulation_order_in = '0;
    logic [1:0]  base_graph;
    logic [1:0]  rv_number;
    logic [3:0]  process_number;
    logic [16:0] available_coded_bits;
    logic [2:0]  modulation_order;
    logic        busy;
    logic        frame_done;
    logic [7:0]  frame_cnt;
    logic        error;
    logic [2:0]  err_stage;

    pusch_chain_ctrl_if sif ();

    pusch_chain_ctrl #(.WDT_W(12), .WDT_LIMIT(WDT_LIMIT)) dut (
        .clk                     (clk),
        .reset                   (reset),
        .enable                  (enable),
        .abort                   (abort),
        .base_graph_in           (base_graph_in),
        .rv_number_in            (rv_number_in),
        .process_number_in       (process_number_in),
        .available_coded_bits_in (available_coded_bits_in),
        .modulation_order_in     (modulation_order_in),
        .stages                  (sif.master),
        .base_graph              (base_graph),
        .rv_number               (rv_number),
        .process_number          (process_number),
        .available_coded_bits    (available_coded_bits),
        .modulation_order        (modulation_order),
        .busy                    (busy),
        .frame_done              (frame_done),
        .frame_cnt               (frame_cnt),
        .error                   (error),
        .err_stage               (err_stage)
    );

    always #5 clk = ~clk;

    // Edge counter: at a negedge, cyc is the number of rising edges seen so far.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          n_checks = 0;
    int          n_errors = 0;
    int          n_frames = 0;
    logic [7:0]  exp_cnt = '0;
    logic [1:0]  lat_bg;
    logic [1:0]  lat_rv;
    logic [3:0]  lat_pn;
    logic [16:0] lat_bits;
    logic [2:0]  lat_mod;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic randomize_cfg();
        base_graph_in           = 2'($urandom);
        rv_number_in            = 2'($urandom);
        process_number_in       = 4'($urandom);
        available_coded_bits_in = 17'($urandom);
        modulation_order_in     = 3'($urandom);
    endtask

    task automatic latch_cfg();
        lat_bg   = base_graph_in;
        lat_rv   = rv_number_in;
        lat_pn   = process_number_in;
        lat_bits = available_coded_bits_in;
        lat_mod  = modulation_order_in;
    endtask

    task automatic check_cfg(input string tag);
        check({tag, "_base_graph"}, base_graph, lat_bg);
        check({tag, "_rv_number"}, rv_number, lat_rv);
        check({tag, "_process_number"}, process_number, lat_pn);
        check({tag, "_coded_bits"}, available_coded_bits, lat_bits);
        check({tag, "_mod_order"}, modulation_order, lat_mod);
    endtask

    // One frame. The model is a schedule: stage i starts at st[i], its done is
    // returned d[i] cycles later, so the next stage starts d[i]+1 edges after.
    task automatic run_frame(input bit fixed, input bit spurious, input int abort_stage,
                             input bit poke_s2, input bit early_next);
        int         d[6];
        int         st[6];
        int         acc, fin, ab, end_t, busy_end, t, cur, seen_done;
        bit         aborting, reached;
        logic [5:0] dn, exp_start, exp_act;
        logic [7:0] cnt_exp;
        aborting = (abort_stage >= 0);
        if (fixed) begin
            base_graph_in           = 2'd2;
            rv_number_in            = 2'd1;
            process_number_in       = 4'd3;
            available_coded_bits_in = 17'd144;
            modulation_order_in     = 3'd2;
        end else begin
            randomize_cfg();
        end
        latch_cfg();
        enable = 1'b1;
        acc = cyc + 1;
        for (int i = 0; i < 6; i++) begin
            d[i]  = fixed ? 1 : int'($urandom_range(1, 4));
            st[i] = (i == 0) ? acc : st[i-1] + d[i-1] + 1;
        end
        fin       = st[5] + d[5] + 1;
        ab        = aborting ? st[abort_stage] + d[abort_stage] + 1 : fin + 100;
        busy_end  = aborting ? ab : fin + 1;
        end_t     = aborting ? ab + 2 : fin + 1;
        seen_done = -1;
        reached   = 1'b0;
        t         = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            t = cyc;
            if (t == acc) enable = 1'b0;
            cur       = -1;
            exp_start = '0;
            for (int i = 0; i < 6; i++) begin
                if (t >= st[i] && t < ((i == 5) ? fin : st[i+1]) && t < ab) cur = i;
                if (t == st[i] && t < ab) exp_start[i] = 1'b1;
            end
            exp_act = (cur >= 0) ? 6'(1 << cur) : 6'd0;
            cnt_exp = (!aborting && t >= fin) ? exp_cnt + 8'd1 : exp_cnt;
            check("stage_start", sif.stage_start, exp_start);
            check("stage_active", sif.stage_active, exp_act);
            check("busy", busy, (t >= acc && t < busy_end));
            check("frame_done", frame_done, (!aborting && t == fin));
            check("frame_cnt", frame_cnt, cnt_exp);
            if (frame_done) seen_done = t;
            dn = spurious ? 6'($urandom) : 6'd0;
            if (cur >= 0) begin
                dn[cur] = (t == st[cur] + d[cur]) ||
                          (spurious && t == st[cur] && $urandom_range(0, 1) == 1);
            end
            sif.stage_done = dn;
            abort = aborting && (t == ab - 1);
            if (poke_s2 && t == st[2] + 1 && t < ab) begin
                randomize_cfg();
                enable = 1'b1;
            end
            if (poke_s2 && t == st[2] + 2) enable = 1'b0;
            if (early_next && !aborting && t == fin) enable = 1'b1;
            if (t >= end_t) begin
                reached = 1'b1;
                break;
            end
        end
        sif.stage_done = '0;
        abort = 1'b0;
        check("frame_end_reached", reached, 1'b1);
        if (fixed) check("min_frame_len", seen_done - acc, 12);
        check_cfg("cfg_hold");
        check("error_after_frame", error, 1'b0);
        if (!aborting) begin
            exp_cnt = exp_cnt + 8'd1;
            n_frames++;
            if (n_frames == 256) check("cnt_wrap", frame_cnt, 8'd0);
        end
    endtask

    // Stage 1 never completes.
    task automatic run_stall();
        int acc, t, s1;
        bit reached;
        randomize_cfg();
        latch_cfg();
        enable  = 1'b1;
        acc     = cyc + 1;
        s1      = acc + 2;
        reached = 1'b0;
`ifdef PUSCH_CTRL_WATCHDOG_EN
        for (int k = 0; k < WDT_LIMIT + 10; k++) begin
            @(negedge clk);
            t = cyc;
            if (t == acc) enable = 1'b0;
            sif.stage_done = (t == acc + 1) ? 6'b000001 : 6'b000000;
            if (t == s1) check("stall_s1_start", sif.stage_start, 6'b000010);
            if (t >= s1 && t < s1 + WDT_LIMIT) begin
                check("stall_s1_active", sif.stage_active, 6'b000010);
                check("stall_no_error_yet", error, 1'b0);
            end
            if (t == s1 + WDT_LIMIT) begin
                check("wdt_error", error, 1'b1);
                check("wdt_err_stage", err_stage, 3'd1);
                check("wdt_active_off", sif.stage_active, 6'b000000);
                check("wdt_busy_in_err", busy, 1'b1);
            end
            if (t == s1 + WDT_LIMIT + 1) begin
                check("wdt_idle", busy, 1'b0);
                check("wdt_error_sticky", error, 1'b1);
                check("wdt_err_stage_sticky", err_stage, 3'd1);
                reached = 1'b1;
                break;
            end
        end
`else
        for (int k = 0; k < 5010; k++) begin
            @(negedge clk);
            t = cyc;
            if (t == acc) enable = 1'b0;
            sif.stage_done = (t == acc + 1) ? 6'b000001 : 6'b000000;
            if (t >= s1 && t <= s1 + 5000 && (t - s1) % 500 == 0) begin
                check("hold_s1_active", sif.stage_active, 6'b000010);
                check("hold_busy", busy, 1'b1);
                check("hold_no_error", error, 1'b0);
            end
            if (t == s1 + 5000) abort = 1'b1;
            if (t == s1 + 5001) begin
                abort = 1'b0;
                check("hold_abort_idle", busy, 1'b0);
                check("hold_error_zero", error, 1'b0);
                reached = 1'b1;
                break;
            end
        end
`endif
        sif.stage_done = '0;
        abort = 1'b0;
        check("stall_end_reached", reached, 1'b1);
        check("stall_frame_cnt", frame_cnt, exp_cnt);
        check_cfg("stall_cfg");
    endtask

    initial begin
        int a;
        sif.stage_done = '0;
        repeat (3) @(negedge clk);
        check("rst_stage_start", sif.stage_start, 6'd0);
        check("rst_stage_active", sif.stage_active, 6'd0);
        check("rst_busy", busy, 1'b0);
        check("rst_frame_done", frame_done, 1'b0);
        check("rst_frame_cnt", frame_cnt, 8'd0);
        check("rst_error", {error, err_stage}, 4'd0);
        check("rst_cfg", {base_graph, rv_number, process_number, available_coded_bits, modulation_order}, 28'd0);
        reset = 1'b1;
        @(negedge clk);
        run_frame(1'b1, 1'b0, -1, 1'b0, 1'b0);
        run_frame(1'b0, 1'b1, -1, 1'b0, 1'b0);
        run_frame(1'b0, 1'b0, 3, 1'b0, 1'b0);
        run_frame(1'b0, 1'b0, -1, 1'b1, 1'b0);
        run_frame(1'b0, 1'b1, -1, 1'b0, 1'b1);
        run_frame(1'b0, 1'b0, -1, 1'b0, 1'b0);
        run_stall();
        run_frame(1'b0, 1'b0, -1, 1'b0, 1'b0);
        for (int it = 0; it < 400 && n_frames < 260; it++) begin
            a = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 5)) : -1;
            run_frame(1'b0, 1'($urandom_range(0, 1)), a,
                      $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
        end
        check("frames_completed", n_frames >= 256, 1'b1);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
